rfphoenix_mem_req_queue: RTL and testbench

Per-core memory request queue sitting between the issue/execute stage and the memory unit. It buffers load/store requests and issues them in order over a valid/ready handshake. It squashes entries of threads being rolled back and keeps a per-thread bitmap of load targets still awaiting a memory response. The response-side FIFO reports completions back via rsp_done.

---
 rtl/rfphoenix_mem_req_queue.sv | 203 ++++++++++++++++++++
 tb/tb_rfphoenix_mem_req_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rfphoenix_mem_req_queue.sv
// ============================================================================
// Module   : rfphoenix_mem_req_queue
// Purpose  : In-order per-core memory request queue with thread rollback
//            squash and per-thread outstanding-load bitmaps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rfphoenix_mem_req_queue #(
    parameter  int NTHREADS = 4,
    parameter  int DEP      = 16,
    parameter  int AWID     = 32,
    parameter  int DWID     = 128,
    parameter  int TGTW     = 7,
    localparam int TW       = (NTHREADS > 1) ? $clog2(NTHREADS) : 1,
    localparam int PW       = $clog2(DEP),
    localparam int CW       = PW + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_v,
    output logic                    req_rdy,
    input  logic [TW-1:0]           req_thread,
    input  logic [TGTW-1:0]         req_tgt,
    input  logic                    req_load,
    input  logic [AWID-1:0]         req_adr,
    input  logic [DWID-1:0]         req_dat,
    input  logic [NTHREADS-1:0]     rollback,
    input  logic                    rsp_done,
    input  logic [TW-1:0]           rsp_thread,
    input  logic [TGTW-1:0]         rsp_tgt,
    output logic                    mem_req_v,
    input  logic                    mem_req_rdy,
    output logic [TW-1:0]           mem_thread,
    output logic [TGTW-1:0]         mem_tgt,
    output logic                    mem_load,
    output logic [AWID-1:0]         mem_adr,
    output logic [DWID-1:0]         mem_dat,
    output logic                    mem_kill,
    output logic [CW-1:0]           cnt,
    output logic                    empty,
    output logic [NTHREADS*128-1:0] pending
);

    localparam int c_NREG = 128;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    logic [DEP-1:0]  r_v;
    logic [TW-1:0]   r_thr  [DEP];
    logic [TGTW-1:0] r_tgt  [DEP];
    logic            r_load [DEP];
    logic [AWID-1:0] r_adr  [DEP];
    logic [DWID-1:0] r_dat  [DEP];

    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_cnt;
    state_t          r_state;

    logic            r_mem_v;
    logic [TW-1:0]   r_mem_thread;
    logic [TGTW-1:0] r_mem_tgt;
    logic            r_mem_load;
    logic [AWID-1:0] r_mem_adr;
    logic [DWID-1:0] r_mem_dat;
    logic            r_mem_kill;

    logic [NTHREADS*c_NREG-1:0] r_pending;
    logic [NTHREADS*c_NREG-1:0] w_pend_nxt;

    logic w_full;
    logic w_empty;
    logic w_enq;
    logic w_head_live;
    logic w_pop;
    logic w_set;

    assign w_full      = (r_cnt == CW'(DEP));
    assign w_empty     = (r_cnt == '0);
    assign w_enq       = req_v & ~w_full;
    assign w_head_live = ~w_empty & r_v[r_rd_ptr] & ~rollback[r_thr[r_rd_ptr]];
    assign w_set       = w_enq & req_load & ~rollback[req_thread];

    // IDLE drains one entry per cycle (dead ones silently); ISSUE pops only on a live back-to-back hand-off
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = ~w_empty;
            S_ISSUE: w_pop = mem_req_rdy & w_head_live;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
        end else begin
            for (int i = 0; i < DEP; i++) begin
                if (rollback[r_thr[i]]) r_v[i] <= 1'b0;
            end
            if (w_enq) r_v[r_wr_ptr] <= ~rollback[req_thread];
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_thr[r_wr_ptr]  <= req_thread;
            r_tgt[r_wr_ptr]  <= req_tgt;
            r_load[r_wr_ptr] <= req_load;
            r_adr[r_wr_ptr]  <= req_adr;
            r_dat[r_wr_ptr]  <= req_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cnt        <= '0;
            r_state      <= S_IDLE;
            r_mem_v      <= 1'b0;
            r_mem_thread <= '0;
            r_mem_tgt    <= '0;
            r_mem_load   <= 1'b0;
            r_mem_adr    <= '0;
            r_mem_dat    <= '0;
            r_mem_kill   <= 1'b0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_enq, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase

            if ((r_state == S_IDLE || mem_req_rdy) && w_head_live) begin
                r_mem_thread <= r_thr[r_rd_ptr];
                r_mem_tgt    <= r_tgt[r_rd_ptr];
                r_mem_load   <= r_load[r_rd_ptr];
                r_mem_adr    <= r_adr[r_rd_ptr];
                r_mem_dat    <= r_dat[r_rd_ptr];
            end

            case (r_state)
                S_IDLE: begin
                    if (w_head_live) begin
                        r_mem_kill <= 1'b0;
                        r_mem_v    <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_rdy) begin
                        if (w_head_live) begin
                            r_mem_kill <= 1'b0;
                        end else begin
                            r_mem_v <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (rollback[r_mem_thread]) begin
                        r_mem_kill <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Set beats clear on the same bit; a thread rollback wipes its bitmap regardless
    always_comb begin
        w_pend_nxt = r_pending;
        if (rsp_done) w_pend_nxt[{rsp_thread, rsp_tgt}] = 1'b0;
        if (w_set)    w_pend_nxt[{req_thread, req_tgt}] = 1'b1;
        for (int n = 0; n < NTHREADS; n++) begin
            if (rollback[n]) w_pend_nxt[n*c_NREG +: c_NREG] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pending <= '0;
        else     r_pending <= w_pend_nxt;
    end

    assign req_rdy    = ~w_full;
    assign cnt        = r_cnt;
    assign empty      = w_empty;
    assign pending    = r_pending;
    assign mem_req_v  = r_mem_v;
    assign mem_thread = r_mem_thread;
    assign mem_tgt    = r_mem_tgt;
    assign mem_load   = r_mem_load;
    assign mem_adr    = r_mem_adr;
    assign mem_dat    = r_mem_dat;
    assign mem_kill   = r_mem_kill;

endmodule

`default_nettype wire

// File: tb/tb_rfphoenix_mem_req_queue.sv
// ============================================================================
// Module   : tb_rfphoenix_mem_req_queue
// Purpose  : Scoreboard bench for rfphoenix_mem_req_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rfphoenix_mem_req_queue;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_v = 1'b0;
    logic         req_rdy;
    logic [1:0]   req_thread = '0;
    logic [6:0]   req_tgt = '0;
    logic         req_load = 1'b0;
    logic [31:0]  req_adr = '0;
    logic [127:0] req_dat = '0;
    logic [3:0]   rollback = '0;
    logic         rsp_done = 1'b0;
    logic [1:0]   rsp_thread = '0;
    logic [6:0]   rsp_tgt = '0;
    logic         mem_req_v;
    logic         mem_req_rdy = 1'b0;
    logic [1:0]   mem_thread;
    logic [6:0]   mem_tgt;
    logic         mem_load;
    logic [31:0]  mem_adr;
    logic [127:0] mem_dat;
    logic         mem_kill;
    logic [4:0]   cnt;
    logic         empty;
    logic [511:0] pending;

    rfphoenix_mem_req_queue dut (
        .clk(clk), .rst(rst),
        .req_v(req_v), .req_rdy(req_rdy), .req_thread(req_thread), .req_tgt(req_tgt),
        .req_load(req_load), .req_adr(req_adr), .req_dat(req_dat),
        .rollback(rollback), .rsp_done(rsp_done), .rsp_thread(rsp_thread), .rsp_tgt(rsp_tgt),
        .mem_req_v(mem_req_v), .mem_req_rdy(mem_req_rdy), .mem_thread(mem_thread),
        .mem_tgt(mem_tgt), .mem_load(mem_load), .mem_adr(mem_adr), .mem_dat(mem_dat),
        .mem_kill(mem_kill), .cnt(cnt), .empty(empty), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]   thr;
        logic [6:0]   tgt;
        logic         load;
        logic [31:0]  adr;
        logic [127:0] dat;
        logic         kill;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [1:0] thr, input logic [6:0] tgt, input logic ld,
                       input logic [31:0] adr, input bit issues, input bit kill);
        req_thread = thr;
        req_tgt    = tgt;
        req_load   = ld;
        req_adr    = adr;
        req_dat    = {4{adr ^ 32'hA5A5_0000}};
        req_v      = 1'b1;
        if (issues) sb.push_back('{thr, tgt, ld, adr, {4{adr ^ 32'hA5A5_0000}}, kill});
        tick();
        req_v = 1'b0;
    endtask

    // Every accepted memory request is matched in order against the scoreboard
    always @(negedge clk) begin
        if (!rst && mem_req_v && mem_req_rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got adr %0h expected no request", mem_adr);
            end else begin
                e = sb.pop_front();
                chk("iss_thread", mem_thread, e.thr);
                chk("iss_tgt",    mem_tgt,    e.tgt);
                chk("iss_load",   mem_load,   e.load);
                chk("iss_adr",    mem_adr,    e.adr);
                chk("iss_dat",    mem_dat,    e.dat);
                chk("iss_kill",   mem_kill,   e.kill);
            end
        end
    end

    logic [127:0] m;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt",     cnt, 0);
        chk("rst_empty",   empty, 1);
        chk("rst_req_rdy", req_rdy, 1);
        chk("rst_mem_v",   mem_req_v, 0);
        chk("rst_kill",    mem_kill, 0);
        chk("rst_pending", {127'b0, |pending}, 0);
        rst = 1'b0;
        tick();

        // single load, two-cycle latency and pending tracking
        mem_req_rdy = 1'b1;
        enq(2'd1, 7'd5, 1'b1, 32'h100, 1, 0);
        chk("lat_early_v", mem_req_v, 0);
        chk("pend_set",    pending[1*128+5], 1);
        tick();
        chk("lat_v",   mem_req_v, 1);
        chk("lat_adr", mem_adr, 32'h100);
        chk("lat_tgt", mem_tgt, 5);
        tick();
        chk("one_done_v", mem_req_v, 0);
        chk("pend_hold",  pending[1*128+5], 1);
        rsp_done = 1'b1; rsp_thread = 2'd1; rsp_tgt = 7'd5;
        tick();
        rsp_done = 1'b0;
        chk("pend_clr", pending[1*128+5], 0);

        // fill: first entry moves into the issue register, so 17 fit before full
        mem_req_rdy = 1'b0;
        for (int i = 0; i < 17; i++)
            enq(2'(i % 4), 7'(i), 1'b0, 32'h1000 + 32'(i * 4), 1, 0);
        chk("full_cnt",  cnt, 16);
        chk("full_rdy",  req_rdy, 0);
        chk("full_memv", mem_req_v, 1);
        chk("full_adr",  mem_adr, 32'h1000);
        enq(2'd0, 7'd99, 1'b0, 32'hDEAD, 0, 0);
        chk("full_rej_cnt", cnt, 16);
        mem_req_rdy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            chk("b2b_v", mem_req_v, 1);
            tick();
        end
        chk("drain_v",     mem_req_v, 0);
        chk("drain_cnt",   cnt, 0);
        chk("drain_empty", empty, 1);

        // rollback of thread 2 among queued loads
        mem_req_rdy = 1'b0;
        enq(2'd0, 7'd10, 1'b1, 32'h2000, 1, 0);
        enq(2'd2, 7'd12, 1'b1, 32'h2004, 0, 0);
        enq(2'd0, 7'd11, 1'b1, 32'h2008, 1, 0);
        enq(2'd2, 7'd13, 1'b1, 32'h200c, 0, 0);
        rollback = 4'b0100;
        tick();
        rollback = 4'b0000;
        m = '0; m[10] = 1'b1; m[11] = 1'b1;
        chk("rb_pend_t2", pending[2*128 +: 128], 0);
        chk("rb_pend_t0", pending[0 +: 128], m);
        chk("rb_cnt",     cnt, 3);
        mem_req_rdy = 1'b1;
        tick();
        chk("rb_dead_v1", mem_req_v, 0);
        tick();
        chk("rb_dead_v2",   mem_req_v, 0);
        chk("rb_dead_cnt2", cnt, 2);
        tick();
        chk("rb_c_v",   mem_req_v, 1);
        chk("rb_c_adr", mem_adr, 32'h2008);
        tick();
        tick();
        chk("rb_end_cnt", cnt, 0);
        chk("rb_end_v",   mem_req_v, 0);

        // rollback while stalled in issue: held stable, killed
        mem_req_rdy = 1'b0;
        enq(2'd3, 7'd20, 1'b0, 32'h300, 1, 1);
        tick();
        chk("stall_v",    mem_req_v, 1);
        chk("stall_kill", mem_kill, 0);
        rollback = 4'b1000;
        tick();
        rollback = 4'b0000;
        chk("kill_v",   mem_req_v, 1);
        chk("kill_adr", mem_adr, 32'h300);
        chk("kill_set", mem_kill, 1);
        tick();
        chk("kill_hold", mem_kill, 1);
        mem_req_rdy = 1'b1;
        tick();
        chk("kill_done_v", mem_req_v, 0);

        // set and clear of the same bit: set wins; rollback beats both
        req_thread = 2'd0; req_tgt = 7'd9; req_load = 1'b1; req_adr = 32'h400;
        req_dat = {4{32'h400 ^ 32'hA5A5_0000}};
        sb.push_back('{2'd0, 7'd9, 1'b1, 32'h400, {4{32'h400 ^ 32'hA5A5_0000}}, 1'b0});
        rsp_done = 1'b1; rsp_thread = 2'd0; rsp_tgt = 7'd9;
        req_v = 1'b1;
        tick();
        req_v = 1'b0;
        chk("setwin_bit", pending[9], 1);
        tick();
        rsp_done = 1'b0;
        chk("clr_bit", pending[9], 0);
        rollback = 4'b0001;
        enq(2'd0, 7'd9, 1'b1, 32'h404, 0, 0);
        rollback = 4'b0000;
        chk("rbwin_bit", pending[9], 0);
        repeat (3) tick();
        chk("rbwin_cnt", cnt, 0);
        chk("rbwin_v",   mem_req_v, 0);

        // asynchronous reset mid-transaction
        mem_req_rdy = 1'b0;
        for (int i = 0; i < 6; i++)
            enq(2'd1, 7'(30 + i), 1'b1, 32'h500 + 32'(i * 4), 0, 0);
        chk("pre_rst_cnt",  cnt, 5);
        chk("pre_rst_v",    mem_req_v, 1);
        chk("pre_rst_pend", {127'b0, |pending}, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_v",     mem_req_v, 0);
        chk("arst_cnt",   cnt, 0);
        chk("arst_empty", empty, 1);
        chk("arst_pend",  {127'b0, |pending}, 0);
        chk("arst_rdy",   req_rdy, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
